// File: rtl/mips_memory.sv
// Unified instruction/data memory for the multicycle MIPS core.
// Word RAM, MMIO window (leds, counters, fault), host loader port.
module mips_memory #(
  parameter int          DEPTH_WORDS = 256,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ADR,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic [7:0]  leds,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [7:0]  leds_q, leds_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] store_q, store_d;
  logic        ld_ready_q;

  logic          ram_hit, mmio_hit;
  logic [AW-1:0] cpu_idx, ld_idx;
  logic          ld_ok;
  logic          ram_we;
  logic [AW-1:0] ram_widx;
  logic [31:0]   ram_wdata;
  logic          set_f, clr_f;

  assign ram_hit  = ADR < RAM_BYTES;
  assign mmio_hit = ADR[31:4] == MMIO_BASE[31:4];
  assign cpu_idx  = ADR[AW+1:2];
  assign ld_idx   = ld_addr[AW+1:2];

  assign ld_ok = ld_valid && ld_ready_q
              && (ld_addr < RAM_BYTES)
              && (ld_addr[1:0] == 2'b00);

  always_comb begin
    RD = 32'h0;
    if (ram_hit) begin
      RD = mem[cpu_idx];
    end else if (mmio_hit) begin
      unique case (ADR[3:2])
        2'd0: RD = {24'h0, leds_q};
        2'd1: RD = cycle_q;
        2'd2: RD = store_q;
        2'd3: RD = {31'h0, fault_q};
        default: RD = 32'h0;
      endcase
    end
  end

  always_comb begin
    leds_d       = leds_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    cycle_d      = cycle_q + 32'd1;
    store_d      = store_q;
    ram_we       = ld_ok;
    ram_widx     = ld_idx;
    ram_wdata    = ld_data;
    set_f        = 1'b0;
    clr_f        = 1'b0;
    if (WE) begin
      if (ADR[1:0] != 2'b00) begin
        set_f = 1'b1;
      end else if (ram_hit) begin
        if (ld_ok) begin
          set_f = 1'b1;
        end else begin
          ram_we    = 1'b1;
          ram_widx  = cpu_idx;
          ram_wdata = WD;
          store_d   = store_q + 32'd1;
        end
      end else if (mmio_hit) begin
        unique case (ADR[3:2])
          2'd0:    leds_d = WD[7:0];
          2'd3:    clr_f  = 1'b1;
          default: ;
        endcase
      end else begin
        set_f = 1'b1;
      end
    end
    if (clr_f) begin
      fault_d      = 1'b0;
      fault_addr_d = 32'h0;
    end else if (set_f) begin
      fault_d = 1'b1;
      if (!fault_q) fault_addr_d = ADR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      leds_q       <= 8'h0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
      cycle_q      <= 32'h0;
      store_q      <= 32'h0;
      ld_ready_q   <= 1'b0;
    end else begin
      leds_q       <= leds_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      cycle_q      <= cycle_d;
      store_q      <= store_d;
      ld_ready_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && ram_we) mem[ram_widx] <= ram_wdata;
  end

  assign ld_ready   = ld_ready_q;
  assign leds       = leds_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_mips_memory.sv
// Self-checking bench for mips_memory.
// Expected values are queued at stimulus time and popped at check time.
module tb_mips_memory;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ADR, WD;
  logic        WE;
  logic [31:0] RD;
  logic        ld_valid;
  logic [31:0] ld_addr, ld_data;
  logic        ld_ready;
  logic [7:0]  leds;
  logic        fault;
  logic [31:0] fault_addr;

  mips_memory #(
    .DEPTH_WORDS(256),
    .INIT_FILE(""),
    .MMIO_BASE(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .ADR(ADR), .WD(WD), .WE(WE), .RD(RD),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_ready(ld_ready),
    .leds(leds), .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  // Drive ADR, let the combinational read settle, then compare RD.
  task automatic rd_chk(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] v);
    ADR = a;
    push(tag, v);
    #1;
    pop_chk(RD);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; ADR = '0; WD = '0; WE = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;

    tick();
    push("rst_leds", 32'h0);  pop_chk({24'h0, leds});
    push("rst_fault", 32'h0); pop_chk({31'h0, fault});
    push("rst_faddr", 32'h0); pop_chk(fault_addr);
    push("rst_ldrdy", 32'h0); pop_chk({31'h0, ld_ready});
    tick();
    push("rst_ldrdy2", 32'h0); pop_chk({31'h0, ld_ready});

    rst = 1'b1;
    rd_chk("cyc0", MB + 32'h4, 32'd0);
    tick();
    push("ldrdy_up", 32'h1); pop_chk({31'h0, ld_ready});
    repeat (4) tick();
    rd_chk("cyc5", MB + 32'h4, 32'd5);

    ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'h2010_0005;
    tick();
    ld_addr = 32'h4; ld_data = 32'hAC01_0004;
    tick();
    ld_addr = 32'h40; ld_data = 32'h1111_2222;
    tick();
    ld_addr = 32'h400; ld_data = 32'h5555_5555;
    tick();
    ld_addr = 32'h6; ld_data = 32'h6666_6666;
    tick();
    ld_valid = 1'b0;
    rd_chk("ld_w0", 32'h0, 32'h2010_0005);
    rd_chk("ld_w4", 32'h4, 32'hAC01_0004);
    rd_chk("ld_st0", MB + 32'h8, 32'h0);
    rd_chk("ld_nofault", MB + 32'hC, 32'h0);

    WE = 1'b1; WD = 32'hDEAD_BEEF;
    rd_chk("wr_old", 32'h40, 32'h1111_2222);
    tick();
    WE = 1'b0;
    rd_chk("wr_new", 32'h40, 32'hDEAD_BEEF);
    rd_chk("st1", MB + 32'h8, 32'h1);

    WE = 1'b1; WD = 32'h0000_0005; ADR = 32'h42;
    tick();
    WE = 1'b0;
    push("mis_fault", 32'h1); pop_chk({31'h0, fault});
    push("mis_faddr", 32'h42); pop_chk(fault_addr);
    WE = 1'b1; ADR = 32'h8000_0000;
    tick();
    WE = 1'b0;
    push("unm_fault", 32'h1); pop_chk({31'h0, fault});
    push("first_wins", 32'h42); pop_chk(fault_addr);
    rd_chk("unm_rd", 32'h8000_0000, 32'h0);
    rd_chk("mis_noram", 32'h40, 32'hDEAD_BEEF);
    rd_chk("f_mmio", MB + 32'hC, 32'h1);
    rd_chk("st_still1", MB + 32'h8, 32'h1);
    WE = 1'b1; ADR = MB + 32'hC;
    tick();
    WE = 1'b0;
    push("clr_fault", 32'h0); pop_chk({31'h0, fault});
    push("clr_faddr", 32'h0); pop_chk(fault_addr);

    ld_valid = 1'b1; ld_addr = 32'h10; ld_data = 32'hCAFE_0001;
    WE = 1'b1; ADR = 32'h10; WD = 32'h1234_5678;
    tick();
    WE = 1'b0; ld_valid = 1'b0;
    rd_chk("col_ld", 32'h10, 32'hCAFE_0001);
    push("col_fault", 32'h1); pop_chk({31'h0, fault});
    push("col_faddr", 32'h10); pop_chk(fault_addr);
    rd_chk("col_st", MB + 32'h8, 32'h1);
    WE = 1'b1; ADR = MB + 32'hC;
    tick();
    WE = 1'b0;

    WE = 1'b1; WD = 32'h0000_01A5;
    rd_chk("led_old", MB, 32'h0);
    tick();
    WE = 1'b0;
    push("led_out", 32'hA5); pop_chk({24'h0, leds});
    rd_chk("led_rd", MB, 32'h0000_00A5);

    rst = 1'b0;
    WE = 1'b1; ADR = 32'h40; WD = 32'h0;
    ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'h0;
    tick();
    push("rst2_leds", 32'h0); pop_chk({24'h0, leds});
    push("rst2_ldrdy", 32'h0); pop_chk({31'h0, ld_ready});
    rst = 1'b1; WE = 1'b0; ld_valid = 1'b0;
    rd_chk("rst2_ram40", 32'h40, 32'hDEAD_BEEF);
    rd_chk("rst2_ram0", 32'h0, 32'h2010_0005);
    rd_chk("rst2_st", MB + 32'h8, 32'h0);

    if (exp_q.size() != 0) check("sb_left", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
